phase_deg_calc: RTL

//  Downstream of the edge-to-edge delay counter. Converts a measured delay (ns) and the

---
 rtl/phase_deg_calc.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/phase_deg_calc.sv
// -----------------------------------------------------------------------------
// phase_deg_calc
//   Converts an edge-to-edge delay and the reference period (both in ns) into
//   phase in 1/SCALE-cycle units: phase = floor(delay * SCALE / period).
//   The quotient comes from a one-bit-per-clock restoring divider. Samples
//   with delay >= period saturate to SCALE-1. 2**AVG_LOG2 results are
//   averaged (floor) before being presented.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   meas_vld_i   1-cycle strobe, delay_ns_i/period_ns_i valid
//   delay_ns_i   measured delay between reference and test edges (ns)
//   period_ns_i  measured reference period (ns)
//   phase_o      averaged phase 0..SCALE-1, held until the next update
//   phase_vld_o  1-cycle pulse when phase_o updates
//   busy_o       high whenever the FSM is not idle
//   div_err_o    1-cycle pulse: an accepted sample had period_ns_i == 0
//   overrun_o    1-cycle pulse: strobe arrived while busy, sample dropped
// -----------------------------------------------------------------------------
module phase_deg_calc #(
    parameter int SCALE    = 3600,
    parameter int SCALE_W  = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               meas_vld_i,
    input  logic [31:0]        delay_ns_i,
    input  logic [31:0]        period_ns_i,
    output logic [SCALE_W-1:0] phase_o,
    output logic               phase_vld_o,
    output logic               busy_o,
    output logic               div_err_o,
    output logic               overrun_o
);

    localparam int NW = 32 + SCALE_W;          // numerator width
    localparam int IW = $clog2(NW);            // divider iteration counter
    localparam int AW = SCALE_W + AVG_LOG2;    // accumulator width
    localparam int CW = AVG_LOG2 + 1;          // sample counter holds 2**AVG_LOG2

    localparam logic [NW-1:0]      SCALE_NW  = NW'(SCALE);
    localparam logic [SCALE_W-1:0] SAT_Q     = SCALE_W'(SCALE - 1);
    localparam logic [CW-1:0]      CNT_FULL  = CW'(2 ** AVG_LOG2);
    localparam logic [IW-1:0]      ITER_LAST = IW'(NW - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_ACC  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        delay_q;
    logic [31:0]        period_q;
    logic [NW-1:0]      num_q;
    logic [31:0]        rem_q;
    logic [SCALE_W-1:0] quo_q;
    logic [IW-1:0]      iter_q;
    logic [AW-1:0]      acc_q;
    logic [CW-1:0]      cnt_q;
    logic [SCALE_W-1:0] phase_q;
    logic               phase_vld_q;
    logic               busy_q;
    logic               div_err_q;
    logic               overrun_q;

    logic [32:0]        shift_s;
    logic [32:0]        trial_s;
    logic [31:0]        rem_d;
    logic               quo_bit_s;
    logic [AW-1:0]      acc_sum_s;
    logic [CW-1:0]      cnt_inc_s;

    // Restoring divider step, accumulator sum and sample count increment.
    always_comb begin
        // Remainder stays below period, so the shifted value needs one extra bit.
        shift_s   = {rem_q, num_q[NW-1]};
        trial_s   = shift_s - {1'b0, period_q};
        quo_bit_s = ~trial_s[32];
        if (trial_s[32]) begin
            rem_d = shift_s[31:0];
        end else begin
            rem_d = trial_s[31:0];
        end
        // Quotient never exceeds SCALE-1, so only its low SCALE_W bits are kept.
        acc_sum_s = acc_q + AW'(quo_q);
        cnt_inc_s = cnt_q + CW'(1);
    end

    // Next-state decode of the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (meas_vld_i) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHK: begin
                if (period_q == 32'd0) begin
                    state_d = S_IDLE;
                end else if (delay_q >= period_q) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_MUL: state_d = S_DIV;
            S_DIV: begin
                if (iter_q == ITER_LAST) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_ACC: begin
                if (cnt_inc_s == CNT_FULL) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            delay_q     <= 32'd0;
            period_q    <= 32'd0;
            num_q       <= '0;
            rem_q       <= 32'd0;
            quo_q       <= '0;
            iter_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            div_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            phase_vld_q <= 1'b0;
            div_err_q   <= 1'b0;
            // A strobe outside IDLE is dropped; the running operation continues.
            overrun_q   <= meas_vld_i && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (meas_vld_i) begin
                        delay_q  <= delay_ns_i;
                        period_q <= period_ns_i;
                    end
                end
                S_CHK: begin
                    if (period_q == 32'd0) begin
                        div_err_q <= 1'b1;
                    end else if (delay_q >= period_q) begin
                        quo_q <= SAT_Q;
                    end
                end
                S_MUL: begin
                    // delay * SCALE fits exactly in 32+SCALE_W bits.
                    num_q  <= NW'(delay_q) * SCALE_NW;
                    rem_q  <= 32'd0;
                    quo_q  <= '0;
                    iter_q <= '0;
                end
                S_DIV: begin
                    num_q  <= num_q << 1;
                    rem_q  <= rem_d;
                    quo_q  <= {quo_q[SCALE_W-2:0], quo_bit_s};
                    iter_q <= iter_q + IW'(1);
                end
                S_ACC: begin
                    acc_q <= acc_sum_s;
                    cnt_q <= cnt_inc_s;
                end
                S_OUT: begin
                    phase_q     <= SCALE_W'(acc_q >> AVG_LOG2);
                    phase_vld_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end
                default: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign phase_o     = phase_q;
    assign phase_vld_o = phase_vld_q;
    assign busy_o      = busy_q;
    assign div_err_o   = div_err_q;
    assign overrun_o   = overrun_q;

endmodule
